// File: rtl/north_buffer_reader.sv
// Read sequencer for the north weight buffer: streams every row num_passes times, hides the
// one-cycle RAM latency behind a 3-entry credit FIFO and presents rows on a valid/ready stream.
module north_buffer_reader #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned NUM_CORES_B   = 1,
  parameter int unsigned TOTAL_INPUT_W = 2,
  parameter int unsigned COL_X         = 16,
  parameter int unsigned PASS_W        = 8,
  // Elements per chunk; must match the top-level chunk size.
  parameter int unsigned CHUNK_SIZE    = 4,
  localparam int unsigned MODULE_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES_B * TOTAL_INPUT_W,
  localparam int unsigned ADDR_WIDTH   = (COL_X > 1) ? $clog2(COL_X) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PASS_W-1:0]       num_passes,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic                    n_rd_en,
  output logic [ADDR_WIDTH-1:0]   n_rd_addr,
  input  logic [MODULE_WIDTH-1:0] n_rd_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MODULE_WIDTH-1:0] out_data,
  output logic                    out_row_last,
  output logic                    out_last
);

  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned EntryW     = MODULE_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(COL_X - 1);
  localparam logic [1:0]            LastPtr  = 2'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [PASS_W-1:0]     passes_q, passes_d;
  logic                  pend_q, pend_row_last_q, pend_last_q;
  logic [1:0]            count_q, count_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;
  logic                  issue, row_end, pass_end, push, pop;
  logic [EntryW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [EntryW-1:0]     head;

  // Credit: entries held plus the read in flight must leave room for this issue.
  assign issue    = (state_q == StRun) &&
                    (({1'b0, count_q} + {2'b00, pend_q}) < 3'(FIFO_DEPTH));
  assign row_end  = (addr_q == LastAddr);
  assign pass_end = (pass_q == passes_q - PASS_W'(1));
  assign push     = pend_q;
  assign head     = fifo_mem[rd_ptr_q];
  assign pop      = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? 2'd0 : wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? 2'd0 : rd_ptr_q + 2'd1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_passes != '0) begin
            state_d  = StRun;
            passes_d = num_passes;
            addr_d   = '0;
            pass_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          if (row_end) begin
            addr_d = '0;
            if (pass_end) state_d = StDrain;
            else          pass_d  = pass_q + PASS_W'(1);
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (pop && head[EntryW-1]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      addr_d   = '0;
      pass_d   = '0;
      passes_d = '0;
      done_d   = 1'b0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      pass_q          <= '0;
      passes_q        <= '0;
      pend_q          <= 1'b0;
      pend_row_last_q <= 1'b0;
      pend_last_q     <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      pass_q          <= pass_d;
      passes_q        <= passes_d;
      pend_q          <= issue & ~flush;
      pend_row_last_q <= row_end;
      pend_last_q     <= row_end & pass_end;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      done_q          <= done_d;
    end
  end

  // Storage is left unreset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pend_last_q, pend_row_last_q, n_rd_dout};
  end

  assign out_valid    = (count_q != 2'd0);
  assign out_data     = out_valid ? head[MODULE_WIDTH-1:0] : '0;
  assign out_row_last = out_valid & head[MODULE_WIDTH];
  assign out_last     = out_valid & head[EntryW-1];
  assign n_rd_en      = issue;
  assign n_rd_addr    = addr_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_north_buffer_reader.sv
// Bench for north_buffer_reader: a table of streaming runs checked beat by beat against a buffer
// model, plus directed sequences for reset, zero passes, flush and mid-run reset.
module tb_north_buffer_reader;
  localparam int MW   = 128;
  localparam int AW   = 4;
  localparam int COLX = 16;
  localparam int PW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] num_passes = '0;
  logic          busy, done, n_rd_en, out_valid, out_row_last, out_last;
  logic [AW-1:0] n_rd_addr;
  logic [MW-1:0] n_rd_dout, out_data;
  logic [MW-1:0] bufm [COLX];
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    int passes;
    int mode;       // 0: ready high, 1: random ready, 2: ready low for 10 cycles
    int beats;
    int row_lasts;
    int last_cyc;   // cycle of the out_last handshake, -1 when not fixed
    bit poke;       // extra start with num_passes=7 while busy
  } vec_t;

  vec_t vecs [5];

  north_buffer_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_passes   (num_passes),
    .flush        (flush),
    .busy         (busy),
    .done         (done),
    .n_rd_en      (n_rd_en),
    .n_rd_addr    (n_rd_addr),
    .n_rd_dout    (n_rd_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_last (out_row_last),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  // Buffer RAM model: one-cycle read latency, poison when not reading.
  always @(posedge clk) n_rd_dout <= n_rd_en ? bufm[n_rd_addr] : {4{32'hDEAD_BEEF}};

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
    chk_int({tag, "_rd_en"}, int'(n_rd_en), 0);
    chk_int({tag, "_rd_addr"}, int'(n_rd_addr), 0);
    chk_int({tag, "_valid"}, int'(out_valid), 0);
    chk_vec({tag, "_data"}, out_data, '0);
    chk_int({tag, "_row_last"}, int'(out_row_last), 0);
    chk_int({tag, "_last"}, int'(out_last), 0);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int cyc = 0, beats = 0, issues = 0, rl = 0, lst = 0, ndone = 0;
    int done_cyc = -1, hs_cyc = -1, first_valid = -1;
    int credit_err = 0, addr_err = 0, stable_err = 0, busy_err = 0, tag_err = 0;
    bit was_stalled = 1'b0;
    logic [MW-1:0] stall_data = '0;
    num_passes = PW'(v.passes);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc > 10);
      endcase
      if (v.poke) begin
        start      = (cyc == 5);
        num_passes = (cyc == 5) ? PW'(7) : PW'(v.passes);
      end
      if (v.mode == 2 && cyc == 11) chk_int({tag, "_stall_issues"}, issues, 3);
      if (first_valid < 0 && out_valid) first_valid = cyc;
      if (n_rd_en) begin
        if (issues - beats >= 3) credit_err++;
        if (int'(n_rd_addr) != issues % COLX) addr_err++;
        issues++;
      end
      if (was_stalled && out_data !== stall_data) stable_err++;
      was_stalled = out_valid && !out_ready;
      stall_data  = out_data;
      if (out_valid && out_ready) begin
        chk_vec($sformatf("%s_data%0d", tag, beats), out_data, bufm[beats % COLX]);
        if (out_row_last) begin
          rl++;
          if (beats % COLX != COLX - 1) tag_err++;
        end
        if (out_last) begin
          lst++;
          hs_cyc = cyc;
          if (beats != v.beats - 1) tag_err++;
        end
        beats++;
      end
      if (busy !== (hs_cyc < 0 || cyc <= hs_cyc)) busy_err++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk_int({tag, "_no_timeout"}, int'(cyc < 400), 1);
    chk_int({tag, "_beats"}, beats, v.beats);
    chk_int({tag, "_issues"}, issues, v.beats);
    chk_int({tag, "_first_valid"}, first_valid, 3);
    chk_int({tag, "_row_lasts"}, rl, v.row_lasts);
    chk_int({tag, "_lasts"}, lst, 1);
    chk_int({tag, "_tag_pos"}, tag_err, 0);
    chk_int({tag, "_done_count"}, ndone, 1);
    chk_int({tag, "_done_cycle"}, done_cyc, hs_cyc + 1);
    chk_int({tag, "_credit"}, credit_err, 0);
    chk_int({tag, "_addr_order"}, addr_err, 0);
    chk_int({tag, "_stall_stable"}, stable_err, 0);
    chk_int({tag, "_busy"}, busy_err, 0);
    if (v.last_cyc >= 0) chk_int({tag, "_last_cycle"}, hs_cyc, v.last_cyc);
  endtask

  initial begin
    int cnt_done, cnt_rd, cnt_valid, beats, cyc;
    vec_t again;
    vecs[0] = '{passes: 1, mode: 0, beats: 16, row_lasts: 1, last_cyc: 18, poke: 1'b0};
    vecs[1] = '{passes: 3, mode: 0, beats: 48, row_lasts: 3, last_cyc: 50, poke: 1'b0};
    vecs[2] = '{passes: 2, mode: 1, beats: 32, row_lasts: 2, last_cyc: -1, poke: 1'b1};
    vecs[3] = '{passes: 1, mode: 2, beats: 16, row_lasts: 1, last_cyc: -1, poke: 1'b0};
    vecs[4] = '{passes: 2, mode: 2, beats: 32, row_lasts: 2, last_cyc: -1, poke: 1'b0};
    again   = vecs[0];
    for (int i = 0; i < COLX; i++) bufm[i] = {4{32'hC0DE_0000 | 32'(i)}};

    #2;
    chk_quiet("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_quiet("post_reset");

    for (int i = 0; i < 5; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // Zero passes: done at T+1, no reads, never busy.
    num_passes = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_int("zero_done_t1", int'(done), 1);
    chk_int("zero_busy_t1", int'(busy), 0);
    cnt_rd = int'(n_rd_en);
    cnt_done = 0;
    cnt_valid = int'(busy);
    for (int i = 0; i < 5; i++) begin
      step();
      cnt_rd += int'(n_rd_en);
      cnt_done += int'(done);
      cnt_valid += int'(busy);
    end
    chk_int("zero_no_reads", cnt_rd, 0);
    chk_int("zero_single_done", cnt_done, 0);
    chk_int("zero_never_busy", cnt_valid, 0);

    // Flush at beat 20 of 32, with a competing start in the same cycle.
    num_passes = PW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    beats = 0;
    cyc = 0;
    while (beats < 20 && cyc < 200) begin
      if (out_valid) beats++;
      step();
      cyc++;
    end
    chk_int("flush_reached_beat20", beats, 20);
    chk_int("flush_pre_valid", int'(out_valid), 1);
    chk_vec("flush_pre_data", out_data, bufm[20 % COLX]);
    flush = 1'b1;
    start = 1'b1;
    num_passes = PW'(1);
    step();
    flush = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    chk_quiet("flush");
    cnt_done = 0;
    cnt_rd = 0;
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt_done += int'(done);
      cnt_rd += int'(n_rd_en);
      cnt_valid += int'(out_valid);
    end
    chk_int("flush_no_done", cnt_done, 0);
    chk_int("flush_no_reads", cnt_rd, 0);
    chk_int("flush_no_valid", cnt_valid, 0);
    run_case(again, "after_flush");

    // Asynchronous reset in the middle of a run.
    num_passes = PW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk_int("rst_mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    step();
    rst_n = 1'b1;
    cnt_done = 0;
    cnt_rd = 0;
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt_done += int'(done);
      cnt_rd += int'(n_rd_en);
      cnt_valid += int'(out_valid);
    end
    out_ready = 1'b0;
    chk_int("rst_mid_no_done", cnt_done, 0);
    chk_int("rst_mid_no_reads", cnt_rd, 0);
    chk_int("rst_mid_no_valid", cnt_valid, 0);
    run_case(again, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
